johnson_decoder_monitor: RTL

- Receive-side companion of the team's 4-bit right-shift Johnson counter.
- Samples the counter's state word, decodes it to a binary phase index and a one-hot phase, and flags illegal codes.
- Checks that successive samples step through the Johnson sequence and keeps a lock state machine plus a saturating error counter.
- Sits next to any Johnson-counter-driven sequencer as a run-time integrity monitor.

---
 rtl/johnson_decoder_monitor.sv | 89 ++++++++
 1 files changed

// File: rtl/johnson_decoder_monitor.sv
// johnson_decoder_monitor: decodes and integrity-checks a right-shift Johnson counter state word
// Optional feature macro: JOHNSON_HOLD_EN (a repeated legal phase is a hold, not a sequence error)
// Ports:
//   clk, reset (sync, active-low)     clock and reset
//   valid_in, jc_in[WIDTH]            sample strobe and Johnson state word
//   phase, phase_onehot, phase_valid  registered decode of the last legal sample
//   illegal, seq_err                  one-cycle error pulses
//   locked, err_count                 lock status and saturating error count
module johnson_decoder_monitor #(
  parameter int WIDTH = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [WIDTH-1:0]              jc_in,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic [2*WIDTH-1:0]            phase_onehot,
  output logic                          phase_valid,
  output logic                          illegal,
  output logic                          seq_err,
  output logic                          locked,
  output logic [ERR_W-1:0]              err_count
);
  localparam int N = 2 * WIDTH;
  localparam int PW = $clog2(N);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t state;
  logic [3:0] step;
  logic have_prev, legal, hold, bad_step;
  logic [PW-1:0] idx, next_phase;
  // Phases 0..WIDTH fill ones from the top; phases above WIDTH drain them from the top.
  always_comb begin
    legal = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++)
      if (jc_in == ((k <= WIDTH) ? ~({WIDTH{1'b1}} >> k) : ({WIDTH{1'b1}} >> (k - WIDTH)))) begin
        legal = 1'b1;
        idx = PW'(k);
      end
  end
  assign next_phase = (phase == PW'(N - 1)) ? '0 : phase + 1'b1;
`ifdef JOHNSON_HOLD_EN
  assign hold = have_prev && legal && idx == phase;
`else
  assign hold = 1'b0;
`endif
  assign bad_step = legal && have_prev && !hold && idx != next_phase;
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= '0;
      phase_onehot <= '0;
      phase_valid <= 1'b0;
      illegal <= 1'b0;
      seq_err <= 1'b0;
      locked <= 1'b0;
      err_count <= '0;
      state <= UNLOCKED;
      step <= '0;
      have_prev <= 1'b0;
    end else begin
      illegal <= 1'b0;
      seq_err <= 1'b0;
      if (valid_in) begin
        have_prev <= legal;
        phase_valid <= legal;
        if (legal) begin
          phase <= idx;
          phase_onehot <= {{(N-1){1'b0}}, 1'b1} << idx;
        end
        if (!legal || bad_step) begin
          illegal <= !legal;
          seq_err <= legal;
          step <= '0;
          state <= UNLOCKED;
          locked <= 1'b0;
          err_count <= (err_count == '1) ? err_count : err_count + 1'b1;
        end else if (have_prev && !hold && state == UNLOCKED) begin
          step <= step + 4'd1;
          if (step + 4'd1 == 4'(LOCK_CNT)) begin
            state <= LOCKED;
            locked <= 1'b1;
          end
        end
      end
    end
  end
endmodule
